retire_monitor: RTL and testbench

RETIRE_MONITOR -- requirements
Module: retire_monitor

---
 rtl/retire_monitor.sv | 171 +++++++++++++++++
 tb/tb_retire_monitor.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/retire_monitor.sv
// Retire-stream monitor: classifies each retiring instruction into a compact
// trace record and queues it in a small FIFO for a downstream drain port.
module retire_monitor #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] PC,
  input  logic [15:0] Inst,
  input  logic        RegWrite,
  input  logic [2:0]  WriteRegister,
  input  logic [15:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [15:0] MemAddress,
  input  logic [15:0] MemData,
  input  logic        Halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  out_kind,
  output logic [15:0] out_inum,
  output logic [15:0] out_pc,
  output logic [2:0]  out_reg,
  output logic [15:0] out_value,
  output logic [15:0] out_addr,
  output logic [15:0] out_mdata,
  output logic [31:0] cycle_count,
  output logic [31:0] inst_count,
  output logic [15:0] drop_count,
  output logic        done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [2:0] K_NOP   = 3'd0;
  localparam logic [2:0] K_REG   = 3'd1;
  localparam logic [2:0] K_LOAD  = 3'd2;
  localparam logic [2:0] K_STORE = 3'd3;
  localparam logic [2:0] K_STU   = 3'd4;
  localparam logic [2:0] K_HALT  = 3'd5;

  typedef struct packed {
    logic [2:0]  kind;
    logic [15:0] inum;
    logic [15:0] pc;
    logic [2:0]  rg;
    logic [15:0] value;
    logic [15:0] addr;
    logic [15:0] mdata;
  } rec_t;

  typedef enum logic [1:0] {RUN, HALT_PEND, DRAIN, DONE} state_t;

  state_t        state, state_nxt;
  rec_t          mem [DEPTH];
  rec_t          rec_in, halt_rec, push_rec, head;
  logic [2:0]    kind;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          push, pop, can_push, drop, retire, capture;

  // The instruction word is not carried in the trace record.
  logic inst_unused;
  assign inst_unused = ^Inst;

  // Classification priority: a write-back wins over Halt, so RegWrite&Halt is a plain reg op.
  always_comb begin
    if (RegWrite && MemWrite)     kind = K_STU;
    else if (RegWrite && MemRead) kind = K_LOAD;
    else if (RegWrite)            kind = K_REG;
    else if (Halt)                kind = K_HALT;
    else if (MemWrite)            kind = K_STORE;
    else                          kind = K_NOP;
  end

  always_comb begin
    rec_in      = '0;
    rec_in.kind = kind;
    rec_in.inum = inst_count[15:0];
    rec_in.pc   = PC;
    if (kind == K_REG || kind == K_LOAD || kind == K_STU) begin
      rec_in.rg    = WriteRegister;
      rec_in.value = WriteData;
    end
    if (kind == K_LOAD || kind == K_STORE || kind == K_STU)
      rec_in.addr = MemAddress;
    if (kind == K_STORE || kind == K_STU)
      rec_in.mdata = MemData;
  end

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign can_push  = (count != FULL_CNT) || pop;

  always_comb begin
    state_nxt = state;
    push_rec  = rec_in;
    push      = 1'b0;
    drop      = 1'b0;
    retire    = 1'b0;
    capture   = 1'b0;
    case (state)
      RUN: begin
        retire = 1'b1;
        if (can_push) begin
          push = 1'b1;
          if (kind == K_HALT) state_nxt = DRAIN;
        end else if (kind == K_HALT) begin
          capture   = 1'b1;
          state_nxt = HALT_PEND;
        end else begin
          drop = 1'b1;
        end
      end
      HALT_PEND: begin
        push_rec = halt_rec;
        if (can_push) begin
          push      = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: if (count_nxt == '0) state_nxt = DONE;
      DONE:  state_nxt = DONE;
      default: state_nxt = RUN;
    endcase
  end

  assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      halt_rec    <= '0;
      cycle_count <= '0;
      inst_count  <= '0;
      drop_count  <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (push)    wr_ptr   <= wr_ptr + AW'(1);
      if (pop)     rd_ptr   <= rd_ptr + AW'(1);
      if (capture) halt_rec <= rec_in;
      if (state != DONE && cycle_count != 32'hFFFF_FFFF)
        cycle_count <= cycle_count + 32'd1;
      if (retire)
        inst_count <= inst_count + 32'd1;
      if (drop && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_rec;
  end

  assign head      = out_valid ? mem[rd_ptr] : '0;
  assign out_kind  = head.kind;
  assign out_inum  = head.inum;
  assign out_pc    = head.pc;
  assign out_reg   = head.rg;
  assign out_value = head.value;
  assign out_addr  = head.addr;
  assign out_mdata = head.mdata;
  assign done      = (state == DONE);

endmodule

// File: tb/tb_retire_monitor.sv
// Directed bench for retire_monitor: classification table plus hand-built
// overflow, halt back-pressure and reset-during-drain sequences.
module tb_retire_monitor;

  logic        clk, rst;
  logic [15:0] PC, Inst, WriteData, MemAddress, MemData;
  logic        RegWrite, MemRead, MemWrite, Halt;
  logic [2:0]  WriteRegister;
  logic        out_valid, out_ready, done;
  logic [2:0]  out_kind, out_reg;
  logic [15:0] out_inum, out_pc, out_value, out_addr, out_mdata, drop_count;
  logic [31:0] cycle_count, inst_count;

  int checks = 0;
  int errors = 0;

  retire_monitor #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .PC(PC), .Inst(Inst),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemAddress(MemAddress), .MemData(MemData),
    .Halt(Halt), .out_valid(out_valid), .out_ready(out_ready),
    .out_kind(out_kind), .out_inum(out_inum), .out_pc(out_pc), .out_reg(out_reg),
    .out_value(out_value), .out_addr(out_addr), .out_mdata(out_mdata),
    .cycle_count(cycle_count), .inst_count(inst_count), .drop_count(drop_count),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc;
    logic        rw;
    logic [2:0]  wr;
    logic [15:0] wd;
    logic        mr;
    logic        mw;
    logic [15:0] ma;
    logic [15:0] md;
    logic        halt;
    logic [2:0]  kind;
    logic [2:0]  rg;
    logic [15:0] value;
    logic [15:0] addr;
    logic [15:0] mdata;
  } vec_t;

  vec_t        vecs [9];
  logic [31:0] drain_exp [4];

  function automatic vec_t mk(input logic [15:0] pc, input logic rw, input logic [2:0] wr,
                              input logic [15:0] wd, input logic mr, input logic mw,
                              input logic [15:0] ma, input logic [15:0] md, input logic halt,
                              input logic [2:0] kind, input logic [2:0] rg,
                              input logic [15:0] value, input logic [15:0] addr,
                              input logic [15:0] mdata);
    vec_t v;
    v = '{pc, rw, wr, wd, mr, mw, ma, md, halt, kind, rg, value, addr, mdata};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_rec(input string name, input logic v, input logic [2:0] kind,
                         input logic [15:0] inum, input logic [15:0] pc, input logic [2:0] rg,
                         input logic [15:0] value, input logic [15:0] addr,
                         input logic [15:0] mdata);
    logic [86:0] act, exp;
    act = {out_valid, out_kind, out_inum, out_pc, out_reg, out_value, out_addr, out_mdata};
    exp = {v, kind, inum, pc, rg, value, addr, mdata};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got v/kind/inum/pc/reg/value/addr/mdata %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] pc, input logic rw, input logic [2:0] wr,
                       input logic [15:0] wd, input logic mr, input logic mw,
                       input logic [15:0] ma, input logic [15:0] md, input logic halt);
    PC = pc; Inst = ~pc; RegWrite = rw; WriteRegister = wr; WriteData = wd;
    MemRead = mr; MemWrite = mw; MemAddress = ma; MemData = md; Halt = halt;
  endtask

  task automatic idle();
    drive(16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    out_ready = 1'b0;
    idle();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = mk(16'h0002, 1, 3, 16'h00AB, 0, 0, 16'h0055, 16'h0077, 0, 1, 3, 16'h00AB, 16'h0000, 16'h0000);
    vecs[1] = mk(16'h0004, 1, 5, 16'hBEEF, 0, 1, 16'h0100, 16'h1234, 0, 4, 5, 16'hBEEF, 16'h0100, 16'h1234);
    vecs[2] = mk(16'h0006, 1, 2, 16'h0011, 0, 0, 16'h0009, 16'h0008, 1, 1, 2, 16'h0011, 16'h0000, 16'h0000);
    vecs[3] = mk(16'h0008, 1, 1, 16'hCAFE, 1, 0, 16'h0200, 16'h3333, 0, 2, 1, 16'hCAFE, 16'h0200, 16'h0000);
    vecs[4] = mk(16'h000A, 0, 7, 16'hFFFF, 0, 1, 16'h0300, 16'h5678, 0, 3, 0, 16'h0000, 16'h0300, 16'h5678);
    vecs[5] = mk(16'h000C, 0, 4, 16'h1111, 0, 0, 16'h0400, 16'h2222, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
    vecs[6] = mk(16'h000E, 0, 6, 16'h4444, 1, 0, 16'h0500, 16'h6666, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
    vecs[7] = mk(16'h0010, 1, 7, 16'h7777, 1, 1, 16'h0600, 16'h8888, 0, 4, 7, 16'h7777, 16'h0600, 16'h8888);
    vecs[8] = mk(16'h0012, 0, 3, 16'h9999, 0, 1, 16'h0700, 16'hAAAA, 1, 5, 0, 16'h0000, 16'h0000, 16'h0000);
    drain_exp[0] = {16'd2, 16'h0102};
    drain_exp[1] = {16'd3, 16'h0103};
    drain_exp[2] = {16'd6, 16'h0077};
    drain_exp[3] = {16'd8, 16'h0200};

    // Reset state
    rst = 1'b1; out_ready = 1'b0; idle();
    tick(); tick();
    chk_rec("reset_rec", 0, 3'd0, 16'h0, 16'h0, 3'd0, 16'h0, 16'h0, 16'h0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_cycle", cycle_count, 32'd0);
    chk("reset_inst", inst_count, 32'd0);
    chk("reset_drop", 32'(drop_count), 32'd0);
    rst = 1'b0;

    // Classification stream: ready held high so each record appears the cycle after it retires
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].pc, vecs[i].rw, vecs[i].wr, vecs[i].wd, vecs[i].mr, vecs[i].mw,
            vecs[i].ma, vecs[i].md, vecs[i].halt);
      tick();
      chk_rec($sformatf("vec%0d", i), 1, vecs[i].kind, 16'(i), vecs[i].pc, vecs[i].rg,
              vecs[i].value, vecs[i].addr, vecs[i].mdata);
    end
    drive(16'h0099, 1, 3'd1, 16'h0101, 0, 0, 16'h0, 16'h0, 0);
    tick();
    chk("tbl_done", 32'(done), 32'd1);
    chk("tbl_valid_low", 32'(out_valid), 32'd0);
    chk("tbl_inst", inst_count, 32'd9);
    chk("tbl_cycle", cycle_count, 32'd10);
    tick();
    chk("done_cycle_frozen", cycle_count, 32'd10);
    chk("done_inst_frozen", inst_count, 32'd9);
    chk("done_sticky", 32'(done), 32'd1);

    // Overflow with ready low, then simultaneous push/pop on a full FIFO
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(16'(2 * i), 1, 3'(i), 16'h0100 + 16'(i), 0, 0, 16'h0, 16'h0, 0);
      tick();
    end
    chk("ovf_inst", inst_count, 32'd6);
    chk("ovf_drop", 32'(drop_count), 32'd2);
    chk("ovf_head", {16'h0, out_inum}, 32'd0);
    out_ready = 1'b1;
    drive(16'h0040, 1, 3'd6, 16'h0077, 0, 0, 16'h0, 16'h0, 0);
    tick();
    chk("full_pushpop_drop", 32'(drop_count), 32'd2);
    chk("full_pushpop_head", {16'h0, out_inum}, 32'd1);
    out_ready = 1'b0;
    drive(16'h0042, 1, 3'd6, 16'h0088, 0, 0, 16'h0, 16'h0, 0);
    tick();
    chk("still_full_drop", 32'(drop_count), 32'd3);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(16'h0050, 1, 3'd2, 16'h0200 + 16'(k), 0, 0, 16'h0, 16'h0, 0);
      tick();
      chk($sformatf("drain_order%0d", k), {out_inum, out_value}, drain_exp[k]);
    end

    // Halt blocked by a full FIFO waits in HALT_PEND and drains last
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(16'h0010 + 16'(i), 1, 3'd1, 16'h0300 + 16'(i), 0, 0, 16'h0, 16'h0, 0);
      tick();
    end
    drive(16'h0050, 0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 1);
    tick();
    chk("halt_nodrop", 32'(drop_count), 32'd0);
    chk("halt_inst", inst_count, 32'd5);
    drive(16'h0060, 1, 3'd4, 16'hDEAD, 0, 0, 16'h0, 16'h0, 0);
    tick();
    chk("halt_pend_frozen", inst_count, 32'd5);
    chk("halt_pend_head", {16'h0, out_inum}, 32'd0);
    out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      chk($sformatf("halt_drain%0d", k), {16'h0, out_inum}, 32'(k));
    end
    tick();
    chk_rec("halt_rec", 1, 3'd5, 16'd4, 16'h0050, 3'd0, 16'h0, 16'h0, 16'h0);
    chk("halt_not_done", 32'(done), 32'd0);
    tick();
    chk("halt_done", 32'(done), 32'd1);
    chk("halt_empty", 32'(out_valid), 32'd0);
    chk("halt_final_inst", inst_count, 32'd5);

    // Asynchronous reset in the middle of DRAIN with three records queued
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(16'h0020 + 16'(i), 1, 3'd3, 16'h0400 + 16'(i), 0, 0, 16'h0, 16'h0, 0);
      tick();
    end
    drive(16'h0070, 0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 1);
    tick();
    out_ready = 1'b1;
    idle();
    tick();
    tick();
    chk("predrain_drop", 32'(drop_count), 32'd1);
    chk("predrain_head", {16'h0, out_inum}, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk_rec("midrst_rec", 0, 3'd0, 16'h0, 16'h0, 3'd0, 16'h0, 16'h0, 16'h0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_cycle", cycle_count, 32'd0);
    chk("midrst_inst", inst_count, 32'd0);
    chk("midrst_drop", 32'(drop_count), 32'd0);
    tick();
    rst = 1'b0;
    drive(16'h0080, 1, 3'd2, 16'h0999, 0, 0, 16'h0, 16'h0, 0);
    tick();
    chk_rec("post_rst_first", 1, 3'd1, 16'd0, 16'h0080, 3'd2, 16'h0999, 16'h0, 16'h0);
    chk("post_rst_inst", inst_count, 32'd1);
    chk("post_rst_cycle", cycle_count, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
